// File: rtl/ps2_host_tx_pkg.sv
// Purpose : shared PS/2 constants (command/response bytes, host-tx FSM states).
// Latency : n/a (definitions only).
// Backpr. : n/a.
package ps2_host_tx_pkg;

    // Host-to-device command bytes
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;

    // Device acknowledge response byte (seen by the receive path)
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Host transmit FSM encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose : 2-FF synchroniser + FILTER_LEN glitch filter + falling-edge detect for one PS/2 line.
// Latency : pad change to o_fall pulse is 2+FILTER_LEN cycles.
// Backpr. : none; free-running.
// Ports   : i_clk/i_rst (async high), i_pad raw pad input,
//           o_level filtered level, o_fall one-cycle pulse on filtered 1->0.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    // Lines idle high, so everything resets to the released level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_pad;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Count consecutive samples disagreeing with the accepted level;
            // any agreeing sample restarts the count.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_level_d & ~r_level;

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose : PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8N+P+stop, check ack.
// Latency : INHIBIT_CYCLES+REQ_CYCLES, then one bit per device clock fall; done ~11 device clocks.
// Backpr. : iSend accepted only while oReady; requests while busy are dropped.
// Ports   : iBusClk/iRst, iData/iSend/oReady/oBusy command side, oDone/oAckErr/oTimeout pulses,
//           iPs2Clk/iPs2Data pad inputs, oPs2ClkOe/oPs2DataOe open-drain pull-low enables.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int REQ_CYCLES     = 2000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       iBusClk,
    input  logic       iRst,
    input  logic [7:0] iData,
    input  logic       iSend,
    output logic       oReady,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAckErr,
    output logic       oTimeout,
    input  logic       iPs2Clk,
    input  logic       iPs2Data,
    output logic       oPs2ClkOe,
    output logic       oPs2DataOe
);

    localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PH_W-1:0] INH_LOAD = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0] REQ_LOAD = PH_W'(REQ_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT_CYCLES);

    logic [2:0]      r_state;
    logic [9:0]      r_shift;
    logic [3:0]      r_bit_cnt;
    logic [PH_W-1:0] r_phase;
    logic [TO_W-1:0] r_to;
    logic            r_ack_bad;
    logic            r_clk_oe;
    logic            r_data_oe;
    logic            r_done;
    logic            r_ack_err;
    logic            r_timeout;

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall;
    logic w_dev_phase;
    logic w_to_fire;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .i_clk   (iBusClk),
        .i_rst   (iRst),
        .i_pad   (iPs2Clk),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .i_clk   (iBusClk),
        .i_rst   (iRst),
        .i_pad   (iPs2Data),
        .o_level (w_data_lvl),
        .o_fall  (w_data_fall)
    );

    // Phases in which the device owns the clock and the watchdog runs.
    assign w_dev_phase = (r_state == ST_SHIFT) || (r_state == ST_ACK) ||
                         (r_state == ST_WAIT_IDLE);

    // Fires on the cycle the watchdog would step from 1 to 0 with no edge seen.
    assign w_to_fire = w_dev_phase && !w_clk_fall && (r_to == TO_W'(1));

    // Watchdog: held loaded outside device phases, reloads on each device fall,
    // otherwise counts down and parks at 0.
    always_ff @(posedge iBusClk or posedge iRst) begin
        if (iRst) begin
            r_to <= TO_LOAD;
        end else if (!w_dev_phase || w_clk_fall) begin
            r_to <= TO_LOAD;
        end else if (r_to != '0) begin
            r_to <= r_to - 1'b1;
        end
    end

    always_ff @(posedge iBusClk or posedge iRst) begin
        if (iRst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_phase   <= '0;
            r_ack_bad <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
            if (w_to_fire) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_timeout <= 1'b1;
                r_state   <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        if (iSend) begin
                            r_shift  <= {1'b1, odd_parity(iData), iData};
                            r_phase  <= INH_LOAD;
                            r_clk_oe <= 1'b1;
                            r_state  <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (r_phase == '0) begin
                            r_data_oe <= 1'b1;   // start bit
                            r_phase   <= REQ_LOAD;
                            r_state   <= ST_REQ;
                        end else begin
                            r_phase <= r_phase - 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (r_phase == '0) begin
                            r_clk_oe  <= 1'b0;   // hand the clock to the device
                            r_bit_cnt <= '0;
                            r_state   <= ST_SHIFT;
                        end else begin
                            r_phase <= r_phase - 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        // Each device fall presents the next frame bit, LSB first.
                        if (w_clk_fall) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[9:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 4'd9) begin
                                r_state <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (w_clk_fall) begin
                            r_ack_bad <= w_data_lvl;
                            r_state   <= ST_WAIT_IDLE;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (w_clk_lvl && w_data_lvl) begin
                            r_done    <= ~r_ack_bad;
                            r_ack_err <= r_ack_bad;
                            r_state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // The data-line fall pulse is only meaningful to the receive path.
    logic w_unused;
    assign w_unused = w_data_fall;

    assign oReady     = (r_state == ST_IDLE);
    assign oBusy      = ~oReady;
    assign oDone      = r_done;
    assign oAckErr    = r_ack_err;
    assign oTimeout   = r_timeout;
    assign oPs2ClkOe  = r_clk_oe;
    assign oPs2DataOe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Purpose : directed bench for ps2_host_tx with a behavioural PS/2 device on the open-drain pair.
// Latency : device clock period 400 cycles; reduced inhibit/request/timeout parameters.
// Backpr. : n/a.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH = 100;
    localparam int REQ = 20;
    localparam int TO  = 5000;
    localparam int FL  = 4;

    logic       iBusClk;
    logic       iRst;
    logic [7:0] iData;
    logic       iSend;
    logic       oReady, oBusy, oDone, oAckErr, oTimeout;
    logic       oPs2ClkOe, oPs2DataOe;
    logic       dev_clk_low, dev_data_low;
    logic       pad_clk, pad_data;

    // Open-drain wired-AND: either side pulling low wins.
    assign pad_clk  = ~(oPs2ClkOe  | dev_clk_low);
    assign pad_data = ~(oPs2DataOe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FL)
    ) dut (
        .iBusClk    (iBusClk),
        .iRst       (iRst),
        .iData      (iData),
        .iSend      (iSend),
        .oReady     (oReady),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oAckErr    (oAckErr),
        .oTimeout   (oTimeout),
        .iPs2Clk    (pad_clk),
        .iPs2Data   (pad_data),
        .oPs2ClkOe  (oPs2ClkOe),
        .oPs2DataOe (oPs2DataOe)
    );

    initial iBusClk = 1'b0;
    always #5 iBusClk = ~iBusClk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_ackerr = 0;
    int n_tmo    = 0;
    int n_clkoe  = 0;

    always @(negedge iBusClk) begin
        if (oDone)     n_done++;
        if (oAckErr)   n_ackerr++;
        if (oTimeout)  n_tmo++;
        if (oPs2ClkOe) n_clkoe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge iBusClk);
        iData = d;
        iSend = 1'b1;
        @(negedge iBusClk);
        iSend = 1'b0;
    endtask

    // Count inhibit-only and request cycles until the host releases the clock.
    task automatic wait_request(output int inh, output int req, output bit ok);
        inh = 0; req = 0; ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (oPs2ClkOe && !oPs2DataOe) inh++;
            else if (oPs2ClkOe && oPs2DataOe) req++;
            else if (!oPs2ClkOe && oPs2DataOe) begin
                ok = 1;
                break;
            end
            @(negedge iBusClk);
        end
    endtask

    // Device: generate n_edges clock falls, sample data mid-high after each;
    // with 11 edges it also drives the ack (low when ack_ok).
    task automatic dev_frame(input int n_edges, input bit ack_ok, output logic [9:0] rx);
        rx = '0;
        repeat (50) @(negedge iBusClk);
        for (int i = 0; i < n_edges && i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (200) @(negedge iBusClk);
            dev_clk_low = 1'b0;
            repeat (100) @(negedge iBusClk);
            rx[i] = pad_data;
            repeat (100) @(negedge iBusClk);
        end
        if (n_edges == 11) begin
            dev_data_low = ack_ok;
            repeat (50) @(negedge iBusClk);
            dev_clk_low = 1'b1;
            repeat (200) @(negedge iBusClk);
            dev_clk_low = 1'b0;
            repeat (100) @(negedge iBusClk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (oReady) begin
                ok = 1;
                break;
            end
            @(negedge iBusClk);
        end
    endtask

    task automatic run_byte(input string tag, input logic [7:0] d, input logic exp_par,
                            input bit ack_ok);
        int d0, a0, t0, inh, req;
        bit ok;
        logic [9:0] rx;
        d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
        send(d);
        check({tag, "_busy"}, 32'(oBusy), 32'd1);
        wait_request(inh, req, ok);
        check({tag, "_inh"}, 32'(inh), 32'(INH));
        check({tag, "_req"}, 32'(req), 32'(REQ));
        check({tag, "_rel"}, 32'(ok), 32'd1);
        dev_frame(11, ack_ok, rx);
        check({tag, "_data"}, 32'(rx[7:0]), 32'(d));
        check({tag, "_par"}, 32'(rx[8]), 32'(exp_par));
        check({tag, "_stop"}, 32'(rx[9]), 32'd1);
        wait_ready(ok);
        check({tag, "_ready"}, 32'(ok), 32'd1);
        repeat (5) @(negedge iBusClk);
        check({tag, "_done"}, 32'(n_done - d0), ack_ok ? 32'd1 : 32'd0);
        check({tag, "_ackerr"}, 32'(n_ackerr - a0), ack_ok ? 32'd0 : 32'd1);
        check({tag, "_tmo"}, 32'(n_tmo - t0), 32'd0);
        check({tag, "_oe"}, {30'd0, oPs2ClkOe, oPs2DataOe}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog n_checks=%0d required=finish", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, t0, c0, inh, req, n;
        bit ok;
        logic [9:0] rx;
        iRst = 1'b1; iData = 8'h00; iSend = 1'b0;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(negedge iBusClk);

        // Reset state
        check("rst_ready", 32'(oReady), 32'd1);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_pulses", {29'd0, oDone, oAckErr, oTimeout}, 32'd0);
        check("rst_oe", {30'd0, oPs2ClkOe, oPs2DataOe}, 32'd0);
        iRst = 1'b0;
        repeat (20) @(negedge iBusClk);

        // Normal bytes: F4 parity 0, 00 parity 1, FF parity 1
        run_byte("f4", CMD_ENABLE, 1'b0, 1'b1);
        run_byte("00", 8'h00, 1'b1, 1'b1);
        run_byte("ff", CMD_RESET, 1'b1, 1'b1);

        // Ack sampled high -> ack error only
        run_byte("nak", CMD_RESET, 1'b1, 1'b0);

        // Device stops after edge 5: oTimeout TO cycles after the host sees
        // that fall (2+FL cycles after the pad), i.e. posedge FL+3+TO from the pad.
        d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
        send(CMD_ENABLE);
        wait_request(inh, req, ok);
        check("tmo_rel", 32'(ok), 32'd1);
        dev_frame(4, 1'b0, rx);
        check("tmo_bits", 32'(rx[3:0]), 32'h4);
        dev_clk_low = 1'b1;
        n = 0;
        while (n < TO + 1000) begin
            @(negedge iBusClk);
            n++;
            if (oTimeout) break;
        end
        check("tmo_cycles", 32'(n), 32'(FL + 3 + TO));
        check("tmo_oe", {30'd0, oPs2ClkOe, oPs2DataOe}, 32'd0);
        check("tmo_ready", 32'(oReady), 32'd1);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge iBusClk);
        check("tmo_cnt", 32'(n_tmo - t0), 32'd1);
        check("tmo_other", 32'((n_done - d0) + (n_ackerr - a0)), 32'd0);

        // Second send while busy is dropped
        d0 = n_done;
        send(CMD_ENABLE);
        iData = 8'h00; iSend = 1'b1;
        @(negedge iBusClk);
        iSend = 1'b0;
        wait_request(inh, req, ok);
        dev_frame(11, 1'b1, rx);
        check("busy_data", 32'(rx[7:0]), 32'(CMD_ENABLE));
        wait_ready(ok);
        c0 = n_clkoe;
        repeat (600) @(negedge iBusClk);
        check("busy_noreq", 32'(n_clkoe - c0), 32'd0);
        check("busy_done", 32'(n_done - d0), 32'd1);
        check("busy_ready", 32'(oReady), 32'd1);

        // Async reset during SHIFT at edge 4 (bit 3 of 00 is 0 -> DataOe=1)
        d0 = n_done; a0 = n_ackerr; t0 = n_tmo;
        send(8'h00);
        wait_request(inh, req, ok);
        dev_frame(3, 1'b0, rx);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge iBusClk);
        check("arst_pre_oe", 32'(oPs2DataOe), 32'd1);
        check("arst_pre_busy", 32'(oBusy), 32'd1);
        #1 iRst = 1'b1;
        #1;
        check("arst_oe", {30'd0, oPs2ClkOe, oPs2DataOe}, 32'd0);
        check("arst_ready", 32'(oReady), 32'd1);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge iBusClk);
        iRst = 1'b0;
        repeat (50) @(negedge iBusClk);
        check("arst_pulses", 32'((n_done - d0) + (n_ackerr - a0) + (n_tmo - t0)), 32'd0);

        // Fresh send after reset: F3 has six ones -> parity 1
        run_byte("f3", CMD_SET_RATE, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
